// File: rtl/move_controller.sv
// Tic-tac-toe move sequencer: validates player/computer requests, drives the
// board decoders, tracks turn, move count and a per-turn computer timeout.
module move_controller #(
  parameter int unsigned PC_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       play,
  input  logic [3:0] player_pos,
  input  logic       pc,
  input  logic [3:0] computer_pos,
  input  logic [8:0] occupied,
  input  logic       game_over,
  input  logic       new_game,
  output logic [3:0] pos_out,
  output logic       player_en,
  output logic       computer_en,
  output logic       turn,
  output logic       illegal_move,
  output logic       pc_timeout,
  output logic [3:0] move_count
);

  localparam int unsigned POS_W   = 4;
  localparam int unsigned TIMER_W = 8;
  localparam logic [POS_W-1:0]   MAX_MOVES  = POS_W'(9);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    PLAYER_WRITE,
    WAIT_PC,
    PC_WRITE,
    GAME_OVER
  } state_e;

  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W-1:0]   count_q, count_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               player_en_q, player_en_d;
  logic               computer_en_q, computer_en_d;
  logic               turn_q, turn_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic               play_legal, pc_legal;

  // Out-of-range cells index into zero padding so only pos <= 8 can be free.
  function automatic logic cell_free(input logic [3:0] pos, input logic [8:0] occ);
    logic [15:0] occ_ext;
    occ_ext = {7'd0, occ};
    return (pos <= 4'd8) && !occ_ext[pos];
  endfunction

  assign play_legal = play && cell_free(player_pos, occupied);
  assign pc_legal   = pc && cell_free(computer_pos, occupied);

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    count_d       = count_q;
    timer_d       = '0;
    illegal_d     = 1'b0;
    timeout_d     = 1'b0;
    player_en_d   = 1'b0;
    computer_en_d = 1'b0;
    turn_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (game_over) begin
          state_d = GAME_OVER;
        end else if (play_legal) begin
          pos_d   = player_pos;
          state_d = PLAYER_WRITE;
        end else if (play) begin
          illegal_d = 1'b1;
        end
      end
      PLAYER_WRITE: begin
        state_d = (game_over || count_q == MAX_MOVES) ? GAME_OVER : WAIT_PC;
      end
      WAIT_PC: begin
        if (game_over) begin
          state_d = GAME_OVER;
        end else if (pc_legal) begin
          pos_d   = computer_pos;
          state_d = PC_WRITE;
        end else begin
          illegal_d = pc;
          if (timer_q == TIMER_LAST) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      PC_WRITE: begin
        state_d = (game_over || count_q == MAX_MOVES) ? GAME_OVER : IDLE;
      end
      GAME_OVER: begin
        state_d = GAME_OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Count a move as the write cycle is entered so it is visible with the enable.
    if ((state_d == PLAYER_WRITE || state_d == PC_WRITE) && count_q < MAX_MOVES) begin
      count_d = count_q + POS_W'(1);
    end

    if (new_game) begin
      state_d   = IDLE;
      pos_d     = '0;
      count_d   = '0;
      timer_d   = '0;
      illegal_d = 1'b0;
      timeout_d = 1'b0;
    end

    player_en_d   = (state_d == PLAYER_WRITE);
    computer_en_d = (state_d == PC_WRITE);
    turn_d        = (state_d == WAIT_PC) || (state_d == PC_WRITE);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pos_q         <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      player_en_q   <= 1'b0;
      computer_en_q <= 1'b0;
      turn_q        <= 1'b0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      player_en_q   <= player_en_d;
      computer_en_q <= computer_en_d;
      turn_q        <= turn_d;
      illegal_q     <= illegal_d;
      timeout_q     <= timeout_d;
    end
  end

  assign pos_out      = pos_q;
  assign player_en    = player_en_q;
  assign computer_en  = computer_en_q;
  assign turn         = turn_q;
  assign illegal_move = illegal_q;
  assign pc_timeout   = timeout_q;
  assign move_count   = count_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed self-checking bench for move_controller with hand-computed expectations.
module tb_move_controller;

  logic       clock;
  logic       reset_n;
  logic       play;
  logic [3:0] player_pos;
  logic       pc;
  logic [3:0] computer_pos;
  logic [8:0] occupied;
  logic       game_over;
  logic       new_game;
  logic [3:0] pos_out;
  logic       player_en;
  logic       computer_en;
  logic       turn;
  logic       illegal_move;
  logic       pc_timeout;
  logic [3:0] move_count;

  int total = 0;
  int bad   = 0;

  move_controller #(.PC_TIMEOUT(15)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .play         (play),
    .player_pos   (player_pos),
    .pc           (pc),
    .computer_pos (computer_pos),
    .occupied     (occupied),
    .game_over    (game_over),
    .new_game     (new_game),
    .pos_out      (pos_out),
    .player_en    (player_en),
    .computer_en  (computer_en),
    .turn         (turn),
    .illegal_move (illegal_move),
    .pc_timeout   (pc_timeout),
    .move_count   (move_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; play = 0; player_pos = 0; pc = 0; computer_pos = 0;
    occupied = '0; game_over = 0; new_game = 0;
    #2 reset_n = 1'b0;
    #1;
    total++; if (pos_out !== 4'd0) begin bad++; $display("FAIL reset_pos got=%0d want=0", pos_out); end
    total++; if ({player_en, computer_en, turn, illegal_move, pc_timeout} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {player_en, computer_en, turn, illegal_move, pc_timeout}); end
    total++; if (move_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", move_count); end
    step(); step();
    reset_n = 1'b1;
  endtask

  task automatic test_player_move();
    play = 1; player_pos = 4;
    step();
    play = 0;
    total++; if (player_en !== 1'b1) begin bad++; $display("FAIL pm_en got=%b want=1", player_en); end
    total++; if (computer_en !== 1'b0) begin bad++; $display("FAIL pm_cen got=%b want=0", computer_en); end
    total++; if (pos_out !== 4'd4) begin bad++; $display("FAIL pm_pos got=%0d want=4", pos_out); end
    total++; if (move_count !== 4'd1) begin bad++; $display("FAIL pm_count got=%0d want=1", move_count); end
    total++; if (turn !== 1'b0) begin bad++; $display("FAIL pm_turn0 got=%b want=0", turn); end
    step();
    total++; if (turn !== 1'b1) begin bad++; $display("FAIL pm_turn1 got=%b want=1", turn); end
    total++; if (player_en !== 1'b0) begin bad++; $display("FAIL pm_en_drop got=%b want=0", player_en); end
  endtask

  // Entered in the first WAIT_PC cycle; timeout is decided at the end of cycle 15.
  task automatic test_timeout();
    for (int i = 1; i <= 14; i++) begin
      step();
      total++; if (pc_timeout !== 1'b0) begin bad++; $display("FAIL to_early cyc=%0d got=%b want=0", i, pc_timeout); end
    end
    step();
    total++; if (pc_timeout !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b want=1", pc_timeout); end
    total++; if (turn !== 1'b0) begin bad++; $display("FAIL to_turn got=%b want=0", turn); end
    step();
    total++; if (pc_timeout !== 1'b0) begin bad++; $display("FAIL to_single got=%b want=0", pc_timeout); end
    total++; if (move_count !== 4'd1) begin bad++; $display("FAIL to_count got=%0d want=1", move_count); end
  endtask

  task automatic test_pc_in_timeout_cycle();
    occupied = 9'b000010000;
    play = 1; player_pos = 0;
    step();
    play = 0;
    total++; if (move_count !== 4'd2) begin bad++; $display("FAIL pt_count2 got=%0d want=2", move_count); end
    step();
    for (int i = 1; i <= 14; i++) step();
    pc = 1; computer_pos = 1;
    step();
    pc = 0;
    total++; if (computer_en !== 1'b1) begin bad++; $display("FAIL pt_cen got=%b want=1", computer_en); end
    total++; if (pc_timeout !== 1'b0) begin bad++; $display("FAIL pt_noto got=%b want=0", pc_timeout); end
    total++; if (pos_out !== 4'd1) begin bad++; $display("FAIL pt_pos got=%0d want=1", pos_out); end
    total++; if (move_count !== 4'd3) begin bad++; $display("FAIL pt_count3 got=%0d want=3", move_count); end
    total++; if (turn !== 1'b1) begin bad++; $display("FAIL pt_turn got=%b want=1", turn); end
    step();
    total++; if ({computer_en, pc_timeout, turn} !== 3'b000) begin
      bad++; $display("FAIL pt_after got=%b want=000", {computer_en, pc_timeout, turn}); end
  endtask

  task automatic test_illegal();
    occupied = 9'b000000100;
    play = 1; player_pos = 9;
    step();
    total++; if (illegal_move !== 1'b1) begin bad++; $display("FAIL il_range got=%b want=1", illegal_move); end
    total++; if (player_en !== 1'b0) begin bad++; $display("FAIL il_range_en got=%b want=0", player_en); end
    total++; if (pos_out !== 4'd1) begin bad++; $display("FAIL il_pos got=%0d want=1", pos_out); end
    player_pos = 2;
    step();
    play = 0;
    total++; if (illegal_move !== 1'b1) begin bad++; $display("FAIL il_occ got=%b want=1", illegal_move); end
    total++; if (player_en !== 1'b0) begin bad++; $display("FAIL il_occ_en got=%b want=0", player_en); end
    step();
    total++; if ({illegal_move, turn} !== 2'b00) begin bad++; $display("FAIL il_end got=%b want=00", {illegal_move, turn}); end
    total++; if (move_count !== 4'd3) begin bad++; $display("FAIL il_count got=%0d want=3", move_count); end
  endtask

  task automatic test_priority();
    occupied = 9'b001000000;
    play = 1; player_pos = 5; pc = 1; computer_pos = 7;
    step();
    play = 0; pc = 0;
    total++; if ({player_en, computer_en} !== 2'b10) begin
      bad++; $display("FAIL pr_both got=%b want=10", {player_en, computer_en}); end
    total++; if (pos_out !== 4'd5) begin bad++; $display("FAIL pr_pos got=%0d want=5", pos_out); end
    total++; if (move_count !== 4'd4) begin bad++; $display("FAIL pr_count got=%0d want=4", move_count); end
    step();
    pc = 1; computer_pos = 6;
    step();
    pc = 0;
    total++; if ({illegal_move, computer_en, turn} !== 3'b101) begin
      bad++; $display("FAIL pr_wait_ill got=%b want=101", {illegal_move, computer_en, turn}); end
    game_over = 1; pc = 1; computer_pos = 8;
    step();
    pc = 0;
    total++; if ({computer_en, turn, illegal_move} !== 3'b000) begin
      bad++; $display("FAIL pr_go_wait got=%b want=000", {computer_en, turn, illegal_move}); end
    game_over = 0; play = 1; player_pos = 3; pc = 1; computer_pos = 2;
    step();
    play = 0; pc = 0;
    total++; if ({player_en, computer_en, illegal_move} !== 3'b000) begin
      bad++; $display("FAIL pr_go_hold got=%b want=000", {player_en, computer_en, illegal_move}); end
    new_game = 1;
    step();
    new_game = 0;
    total++; if (move_count !== 4'd0) begin bad++; $display("FAIL pr_ng_count got=%0d want=0", move_count); end
    total++; if (pos_out !== 4'd0) begin bad++; $display("FAIL pr_ng_pos got=%0d want=0", pos_out); end
    game_over = 1; play = 1; player_pos = 3;
    step();
    play = 0; game_over = 0;
    total++; if ({player_en, pos_out} !== 5'b0) begin
      bad++; $display("FAIL pr_go_idle got=%b want=00000", {player_en, pos_out}); end
    new_game = 1;
    step();
    new_game = 0;
  endtask

  task automatic test_nine_moves();
    occupied = '0;
    for (int k = 0; k <= 8; k++) begin
      if (k % 2 == 0) begin
        play = 1; player_pos = 4'(k);
        step();
        play = 0;
        total++; if (player_en !== 1'b1) begin bad++; $display("FAIL nm_pen k=%0d got=%b want=1", k, player_en); end
      end else begin
        pc = 1; computer_pos = 4'(k);
        step();
        pc = 0;
        total++; if (computer_en !== 1'b1) begin bad++; $display("FAIL nm_cen k=%0d got=%b want=1", k, computer_en); end
      end
      total++; if (move_count !== 4'(k + 1)) begin
        bad++; $display("FAIL nm_count k=%0d got=%0d want=%0d", k, move_count, k + 1); end
      step();
    end
    total++; if (turn !== 1'b0) begin bad++; $display("FAIL nm_turn got=%b want=0", turn); end
    play = 1; player_pos = 0;
    step();
    play = 0;
    total++; if ({player_en, illegal_move} !== 2'b00) begin
      bad++; $display("FAIL nm_over got=%b want=00", {player_en, illegal_move}); end
    total++; if (move_count !== 4'd9) begin bad++; $display("FAIL nm_sat got=%0d want=9", move_count); end
    new_game = 1;
    step();
    new_game = 0;
    total++; if ({move_count, pos_out} !== 8'd0) begin
      bad++; $display("FAIL nm_new got=%0d/%0d want=0/0", move_count, pos_out); end
    play = 1; player_pos = 8;
    step();
    play = 0;
    total++; if (player_en !== 1'b1) begin bad++; $display("FAIL nm_restart got=%b want=1", player_en); end
    step();
  endtask

  task automatic test_reset_mid_write();
    new_game = 1;
    step();
    new_game = 0;
    play = 1; player_pos = 5;
    step();
    play = 0;
    total++; if (player_en !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b want=1", player_en); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (player_en !== 1'b0) begin bad++; $display("FAIL rm_en got=%b want=0", player_en); end
    total++; if ({pos_out, move_count, turn} !== 9'd0) begin
      bad++; $display("FAIL rm_vals got=%0d/%0d/%b want=0/0/0", pos_out, move_count, turn); end
    step();
    reset_n = 1'b1;
    play = 1; player_pos = 2;
    step();
    play = 0;
    total++; if ({player_en, move_count} !== 5'b10001) begin
      bad++; $display("FAIL rm_first got=%b/%0d want=1/1", player_en, move_count); end
  endtask

  initial begin
    test_reset();
    test_player_move();
    test_timeout();
    test_pc_in_timeout_cycle();
    test_illegal();
    test_priority();
    test_nine_moves();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_controller.md
MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 Parameter PC_TIMEOUT, default 15: the number of cycles allowed in WAIT_PC before the computer turn is forfeited; legal range is 2..255.
REQ-002 clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 play  input  1  player move request, sampled every cycle.
REQ-005 player_pos  input  4  player cell index, 0..8.
REQ-006 pc  input  1  computer move request, sampled every cycle.
REQ-007 computer_pos  input  4  computer cell index, 0..8.
REQ-008 occupied  input  9  board occupancy, bit i = cell i taken.
REQ-009 game_over  input  1  win or draw flag from the board checker, level.
REQ-010 new_game  input  1  synchronous restart request.
REQ-011 pos_out  output  4  cell index driven to both position decoders.
REQ-012 player_en  output  1  enable for the player-board decoder.
REQ-013 computer_en  output  1  enable for the computer-board decoder.
REQ-014 turn  output  1  turn indicator: 0 = player, 1 = computer.
REQ-015 illegal_move  output  1  one-cycle pulse on a rejected request.
REQ-016 pc_timeout  output  1  one-cycle pulse when the computer turn is forfeited.
REQ-017 move_count  output  4  count of accepted moves, 0..9.

Function
REQ-018 The FSM SHALL have five states: IDLE, PLAYER_WRITE, WAIT_PC, PC_WRITE and GAME_OVER; all outputs SHALL be registered.
REQ-019 A request is legal only if pos <= 8 and occupied[pos] = 0; any other request is illegal.
REQ-020 IDLE, play=1 and legal: latch player_pos into pos_out and go to PLAYER_WRITE.
REQ-021 IDLE, play=1 and illegal: assert illegal_move for the next cycle only, remain in IDLE, and leave pos_out unchanged.
REQ-022 IDLE: pc is ignored, including when play=1 in the same cycle.
REQ-023 PLAYER_WRITE: assert player_en for exactly one cycle, increment move_count, then go to WAIT_PC with the timer at 0.
REQ-024 WAIT_PC, pc=1 and legal: latch computer_pos into pos_out and go to PC_WRITE.
REQ-025 WAIT_PC, pc=1 and illegal: pulse illegal_move for one cycle and remain in WAIT_PC; the timer keeps counting.
REQ-026 WAIT_PC timer: 8-bit, increments every cycle spent in WAIT_PC.
REQ-027 WAIT_PC timeout: when the timer equals PC_TIMEOUT-1 and no legal pc is present, pulse pc_timeout for one cycle and go to IDLE.
REQ-028 WAIT_PC, legal pc in the timeout cycle: the legal pc wins; there is no pc_timeout pulse.
REQ-029 WAIT_PC: play is ignored.
REQ-030 PC_WRITE: assert computer_en for exactly one cycle, increment move_count, then go to IDLE.
REQ-031 Enable latency: player_en or computer_en SHALL be high in the cycle immediately after the legal request is sampled.
REQ-032 Enable exclusivity: player_en and computer_en SHALL never be high together.
REQ-033 turn SHALL be 0 in IDLE, PLAYER_WRITE and GAME_OVER, and 1 in WAIT_PC and PC_WRITE.
REQ-034 game_over=1 in IDLE or WAIT_PC: go to GAME_OVER, taking priority over any play or pc request in the same cycle.
REQ-035 game_over=1 in PLAYER_WRITE or PC_WRITE: the write completes, then the FSM goes to GAME_OVER.
REQ-036 move_count saturates at 9; on reaching 9, the next state is GAME_OVER regardless of game_over.
REQ-037 GAME_OVER: ignore play and pc; no enables and no pulses; leave only on new_game.
REQ-038 new_game=1 in any state: go to IDLE next cycle; clear move_count, timer and pos_out; deassert all pulses and enables; this overrides every other input.

Reset
REQ-039 reset_n=0 SHALL immediately force IDLE with pos_out=0, player_en=0, computer_en=0, turn=0, illegal_move=0, pc_timeout=0, move_count=0 and timer=0, including when asserted mid-write.
REQ-040 After reset_n rises, the first request SHALL be sampled on the first rising clock edge.

Verification
REQ-041 From reset, occupied=0, play with player_pos=4 -> next cycle player_en=1, pos_out=4, move_count=1; the following cycle turn=1.
REQ-042 In IDLE, play with player_pos=9, then with player_pos=2 while occupied[2]=1 -> two illegal_move pulses, no player_en, state stays IDLE.
REQ-043 In WAIT_PC with PC_TIMEOUT=15 and no pc -> pc_timeout pulses 15 cycles after WAIT_PC entry, turn=0; a legal pc sent in cycle 15 instead gives computer_en and no timeout.
REQ-044 In IDLE, play and pc both legal in the same cycle -> only player_en; game_over together with a legal play -> GAME_OVER, no enable.
REQ-045 Nine accepted alternating moves -> move_count=9 and GAME_OVER; then new_game -> IDLE, move_count=0, pos_out=0.
REQ-046 reset_n low during PLAYER_WRITE -> player_en drops asynchronously, all outputs at reset values.
